ax_cycle_branch_ctrl: RTL and testbench
=======================================

// Module: ax_cycle_branch_ctrl
// PURPOSE
//  Sequencer for the cycle-threshold approximate-branch decider in the fetch unit. Owns the cycle
//  counter, region begin-cycle and threshold registers the decider compares
//  (taken when cycleCounter > beginCycle + threshold). Arms on CSR enable, opens a window at
//  approximate-region begin, and closes it at region end or pipeline flush.
//  Also counts forced-taken fetch cycles for software.
// PARAMETERS
//  DATA_WIDTH   32  width of counter/begin/threshold/CSR data (matches DataPath)
//  STAT_WIDTH   16  width of saturating forced-taken statistic
// PORTS
//  clk            in   1           clock
//  rst            in   1           reset, asynchronous, active-low
//  csrWe          in   1           CSR write strobe
//  csrAddr        in   2           0=CTRL(b0 enable, b1 clear stats, W1 pulse), 1=THRESHOLD, 2=BEGIN(RO), 3=STATS(RO)
//  csrWData       in   DATA_WIDTH  CSR write data
//  csrRData       out  DATA_WIDTH  CSR read data, combinational on csrAddr
//  regionBegin    in   1           commit of approximate-region start marker
//  regionEnd      in   1           commit of approximate-region end marker
//  flush          in   1           pipeline recovery; aborts open window
//  decidTakenAny  in   1           OR of decider brDecidCycTaken[] this cycle
//  cycleCounter   out  DATA_WIDTH  to decider
//  beginCycle     out  DATA_WIDTH  to decider
//  threshold      out  DATA_WIDTH  to decider (active copy)
//  windowOpen     out  1           state is COUNT or EXPIRED
//  windowExpired  out  1           state is EXPIRED
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; cycleCounter, beginCycle, threshold, thrShadow, stats, enable = 0;
//   all outputs 0. Deassertion is taken synchronously at the next clk edge.
//  cycleCounter: +1 every cycle in all states, wraps modulo 2^DATA_WIDTH, except at rebase (below).
//  THRESHOLD write updates thrShadow only; threshold <= thrShadow on each accepted regionBegin.
//   A write in the same cycle as regionBegin is used by that region (write data forwarded).
//  States:
//   IDLE    : enable=0. CTRL write with b0=1 -> ARMED.
//   ARMED   : regionBegin & !regionEnd & !flush -> COUNT; latch beginCycle<=cycleCounter,
//             threshold<=thrShadow. regionBegin together with regionEnd or flush: ignored, stay ARMED.
//   COUNT   : cycleCounter > beginCycle+threshold (DATA_WIDTH+1-bit sum, no wrap) -> EXPIRED.
//             regionEnd or flush -> ARMED (priority over expiry).
//   EXPIRED : regionEnd or flush -> ARMED. regionBegin alone ignored (no nesting).
//   Any state: CTRL write with b0=0 -> IDLE next cycle; beginCycle/threshold held.
//  Rebase: on an accepted regionBegin, if cycleCounter+thrShadow+1 >= 2^DATA_WIDTH, then
//   cycleCounter<=0 and beginCycle<=0 on that edge, so decider compare never wraps in-window.
//  Expiry registered: windowExpired rises 1 cycle after the cycle where compare first true.
//  Stats: +1 per cycle with decidTakenAny=1 in EXPIRED, saturates at all-ones; CTRL b1=1 clears
//   (clear wins over same-cycle increment). decidTakenAny outside EXPIRED is ignored.
//  csrRData: CTRL={..0,enable}, THRESHOLD=thrShadow, BEGIN=beginCycle, STATS zero-extended.
//  Writes to addr 2/3 ignored. Reset mid-window: returns to IDLE, stats lost.
// TESTING
//  Reset, enable, THRESHOLD=5, regionBegin at cycleCounter=100 -> beginCycle=100; windowExpired
//   first 1 in the cycle after cycleCounter=106; decider sees taken while expired.
//  THRESHOLD=5 then write 9 while in COUNT -> current window still expires at 106; next region
//   uses 9.
//  cycleCounter=0xFFFF_FFF0, THRESHOLD=0x20, regionBegin -> cycleCounter and beginCycle both 0
//   next cycle; expiry after counter reaches 0x21.
//  regionBegin+regionEnd same cycle in ARMED -> stays ARMED, beginCycle unchanged; flush in EXPIRED
//   -> ARMED, windowOpen=0 next cycle.
//  EXPIRED with decidTakenAny=1 for 70000 cycles, STAT_WIDTH=16 -> STATS=0xFFFF; CTRL write
//   b1=1 -> 0.
//  rst asserted asynchronously mid-COUNT (between edges) -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/ax_cycle_branch_ctrl.sv
// Sequencer for the cycle-threshold approximate-branch decider: owns the free-running cycle
// counter, the region begin cycle and the active threshold, and tracks the window lifecycle.
module ax_cycle_branch_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csrWe,
    input  logic [1:0]            csrAddr,
    input  logic [DATA_WIDTH-1:0] csrWData,
    output logic [DATA_WIDTH-1:0] csrRData,
    input  logic                  regionBegin,
    input  logic                  regionEnd,
    input  logic                  flush,
    input  logic                  decidTakenAny,
    output logic [DATA_WIDTH-1:0] cycleCounter,
    output logic [DATA_WIDTH-1:0] beginCycle,
    output logic [DATA_WIDTH-1:0] threshold,
    output logic                  windowOpen,
    output logic                  windowExpired,
    output logic [1:0]            dbgState
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_COUNT   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_win_open;
    logic                  r_win_exp;
    logic                  r_enable;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_begin;
    logic [DATA_WIDTH-1:0] r_thr;
    logic [DATA_WIDTH-1:0] r_thr_shadow;
    logic [STAT_WIDTH-1:0] r_stats;

    logic                  w_ctrl_wr;
    logic                  w_thr_wr;
    logic                  w_disable;
    logic                  w_close;
    logic                  w_accept;
    logic                  w_rebase;
    logic                  w_expire_cmp;
    logic                  w_stat_inc;
    logic [DATA_WIDTH-1:0] w_thr_eff;
    logic [DATA_WIDTH+1:0] w_rebase_sum;
    logic [DATA_WIDTH:0]   w_limit;

    assign w_ctrl_wr = csrWe && (csrAddr == 2'd0);
    assign w_thr_wr  = csrWe && (csrAddr == 2'd1);
    assign w_disable = w_ctrl_wr && !csrWData[0];
    assign w_close   = regionEnd || flush;

    // A THRESHOLD write landing with regionBegin is forwarded into that region.
    assign w_thr_eff = w_thr_wr ? csrWData : r_thr_shadow;
    assign w_accept  = (r_state == S_ARMED) && regionBegin && !w_close && !w_disable;

    // Rebase when the window end would not fit in the counter, so the compare never wraps.
    assign w_rebase_sum = {2'b00, r_cnt} + {2'b00, w_thr_eff} + {{(DATA_WIDTH+1){1'b0}}, 1'b1};
    assign w_rebase     = w_accept && (w_rebase_sum[DATA_WIDTH+1:DATA_WIDTH] != 2'b00);

    assign w_limit      = {1'b0, r_begin} + {1'b0, r_thr};
    assign w_expire_cmp = ({1'b0, r_cnt} > w_limit);
    assign w_stat_inc   = (r_state == S_EXPIRED) && decidTakenAny && !(&r_stats);

    always_comb begin
        w_state_nxt = r_state;
        if (w_disable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_ctrl_wr) w_state_nxt = S_ARMED;
                S_ARMED:   if (w_accept) w_state_nxt = S_COUNT;
                S_COUNT: begin
                    if (w_close)           w_state_nxt = S_ARMED;
                    else if (w_expire_cmp) w_state_nxt = S_EXPIRED;
                end
                S_EXPIRED: if (w_close) w_state_nxt = S_ARMED;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_win_open <= 1'b0;
            r_win_exp  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_win_open <= (w_state_nxt == S_COUNT) || (w_state_nxt == S_EXPIRED);
            r_win_exp  <= (w_state_nxt == S_EXPIRED);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable     <= 1'b0;
            r_cnt        <= '0;
            r_begin      <= '0;
            r_thr        <= '0;
            r_thr_shadow <= '0;
            r_stats      <= '0;
        end else begin
            if (w_ctrl_wr) r_enable <= csrWData[0];
            if (w_thr_wr)  r_thr_shadow <= csrWData;

            if (w_rebase) r_cnt <= '0;
            else          r_cnt <= r_cnt + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

            if (w_accept) begin
                r_begin <= w_rebase ? '0 : r_cnt;
                r_thr   <= w_thr_eff;
            end

            // Clear takes precedence over a same-cycle increment.
            if (w_ctrl_wr && csrWData[1]) r_stats <= '0;
            else if (w_stat_inc)          r_stats <= r_stats + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        csrRData = '0;
        case (csrAddr)
            2'd0:    csrRData = {{(DATA_WIDTH-1){1'b0}}, r_enable};
            2'd1:    csrRData = r_thr_shadow;
            2'd2:    csrRData = r_begin;
            default: csrRData = DATA_WIDTH'(r_stats);
        endcase
    end

    assign cycleCounter  = r_cnt;
    assign beginCycle    = r_begin;
    assign threshold     = r_thr;
    assign windowOpen    = r_win_open;
    assign windowExpired = r_win_exp;
    assign dbgState      = r_state;

endmodule

// File: tb/tb_ax_cycle_branch_ctrl.sv
// Bench for ax_cycle_branch_ctrl: a 32-bit instance driven by a vector table and directed
// sequences, and an 8-bit/4-bit-stat instance for counter wrap and stat saturation.
module tb_ax_cycle_branch_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        csrWe;
    logic [1:0]  csrAddr;
    logic [31:0] csrWData;
    logic        regionBegin, regionEnd, flush, decidTakenAny;

    logic [31:0] a_rdata, a_cnt, a_beg, a_thr;
    logic        a_open, a_exp;
    logic [1:0]  a_state;
    logic [7:0]  b_rdata, b_cnt, b_beg, b_thr;
    logic        b_open, b_exp;
    logic [1:0]  b_state;

    ax_cycle_branch_ctrl #(.DATA_WIDTH(32), .STAT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .csrWe(csrWe), .csrAddr(csrAddr), .csrWData(csrWData),
        .csrRData(a_rdata), .regionBegin(regionBegin), .regionEnd(regionEnd), .flush(flush),
        .decidTakenAny(decidTakenAny), .cycleCounter(a_cnt), .beginCycle(a_beg),
        .threshold(a_thr), .windowOpen(a_open), .windowExpired(a_exp), .dbgState(a_state)
    );

    ax_cycle_branch_ctrl #(.DATA_WIDTH(8), .STAT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .csrWe(csrWe), .csrAddr(csrAddr), .csrWData(csrWData[7:0]),
        .csrRData(b_rdata), .regionBegin(regionBegin), .regionEnd(regionEnd), .flush(flush),
        .decidTakenAny(decidTakenAny), .cycleCounter(b_cnt), .beginCycle(b_beg),
        .threshold(b_thr), .windowOpen(b_open), .windowExpired(b_exp), .dbgState(b_state)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;   // bench model of the cycle counter

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drv(input logic we, input logic [1:0] a, input logic [31:0] wd,
                       input logic rb, input logic re, input logic fl, input logic dt);
        csrWe = we; csrAddr = a; csrWData = wd;
        regionBegin = rb; regionEnd = re; flush = fl; decidTakenAny = dt;
    endtask

    task automatic idle();
        drv(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are set at the falling edge; one rising edge passes; return at the next falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rd_a(input logic [1:0] a, input logic [31:0] exp, input string name);
        csrWe = 1'b0; csrAddr = a;
        #1;
        chk(name, a_rdata, exp);
    endtask

    task automatic rd_b(input logic [1:0] a, input logic [31:0] exp, input string name);
        csrWe = 1'b0; csrAddr = a;
        #1;
        chk(name, {24'd0, b_rdata}, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        rb, re, fl, dt;
        logic [31:0] e_beg, e_thr;
        logic        e_open, e_exp;
        logic [1:0]  raddr;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] a, logic [31:0] wd,
                                logic rb, logic re, logic fl, logic dt,
                                logic [31:0] beg, logic [31:0] thr, logic op, logic ex,
                                logic [1:0] ra, logic [31:0] rd);
        vec_t v;
        v.we = we; v.addr = a; v.wd = wd; v.rb = rb; v.re = re; v.fl = fl; v.dt = dt;
        v.e_beg = beg; v.e_thr = thr; v.e_open = op; v.e_exp = ex; v.raddr = ra; v.e_rd = rd;
        return v;
    endfunction

    vec_t tv[22];

    initial begin
        logic [31:0] c0;
        logic [31:0] wd;

        // Row k leaves the counter at k+1 (one edge per row, counting from reset release).
        tv[0]  = mk(1, 0, 32'h1,  0, 0, 0, 0,  0,  0, 0, 0,  0, 1);  // enable -> ARMED
        tv[1]  = mk(1, 1, 32'h3,  0, 0, 0, 0,  0,  0, 0, 0,  1, 3);  // THRESHOLD=3
        tv[2]  = mk(0, 0, 32'h0,  1, 1, 0, 0,  0,  0, 0, 0,  2, 0);  // begin+end ignored
        tv[3]  = mk(0, 0, 32'h0,  1, 0, 1, 0,  0,  0, 0, 0,  3, 0);  // begin+flush ignored
        tv[4]  = mk(0, 0, 32'h0,  1, 0, 0, 0,  4,  3, 1, 0,  2, 4);  // begin at cnt=4
        tv[5]  = mk(0, 0, 32'h0,  0, 0, 0, 0,  4,  3, 1, 0,  1, 3);
        tv[6]  = mk(0, 0, 32'h0,  0, 0, 0, 0,  4,  3, 1, 0,  0, 1);
        tv[7]  = mk(0, 0, 32'h0,  0, 0, 0, 1,  4,  3, 1, 0,  3, 0);  // taken in COUNT ignored
        tv[8]  = mk(0, 0, 32'h0,  0, 0, 0, 0,  4,  3, 1, 1,  3, 0);  // cnt 8 > 7 -> EXPIRED
        tv[9]  = mk(0, 0, 32'h0,  1, 0, 0, 0,  4,  3, 1, 1,  3, 0);  // no nesting
        tv[10] = mk(0, 0, 32'h0,  0, 0, 0, 1,  4,  3, 1, 1,  3, 1);
        tv[11] = mk(0, 0, 32'h0,  0, 0, 0, 1,  4,  3, 1, 1,  3, 2);
        tv[12] = mk(0, 0, 32'h0,  0, 1, 0, 1,  4,  3, 0, 0,  3, 3);  // end, last count
        tv[13] = mk(0, 0, 32'h0,  0, 0, 0, 1,  4,  3, 0, 0,  3, 3);  // taken in ARMED ignored
        tv[14] = mk(1, 1, 32'h0,  1, 0, 0, 0, 14,  0, 1, 0,  1, 0);  // write forwarded
        tv[15] = mk(0, 0, 32'h0,  0, 0, 0, 0, 14,  0, 1, 1,  2, 14);
        tv[16] = mk(0, 0, 32'h0,  0, 0, 1, 0, 14,  0, 0, 0,  3, 3);  // flush in EXPIRED
        tv[17] = mk(1, 0, 32'h0,  1, 0, 0, 0, 14,  0, 0, 0,  0, 0);  // disable wins
        tv[18] = mk(0, 0, 32'h0,  1, 0, 0, 0, 14,  0, 0, 0,  2, 14); // begin in IDLE ignored
        tv[19] = mk(1, 0, 32'h3,  0, 0, 0, 0, 14,  0, 0, 0,  3, 0);  // enable + clear stats
        tv[20] = mk(1, 2, 32'h55, 0, 0, 0, 0, 14,  0, 0, 0,  2, 14); // BEGIN is read-only
        tv[21] = mk(1, 3, 32'h55, 0, 0, 0, 0, 14,  0, 0, 0,  0, 1);  // STATS is read-only

        rst_a = 1'b0;
        rst_b = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("reset cnt", a_cnt, 0);
        chk("reset beg", a_beg, 0);
        chk("reset thr", a_thr, 0);
        chk("reset open", {31'd0, a_open}, 0);
        chk("reset exp", {31'd0, a_exp}, 0);
        rd_a(2'd0, 0, "reset ctrl");

        rst_a = 1'b1;
        cyc = 0;
        for (int i = 0; i < 22; i++) begin
            drv(tv[i].we, tv[i].addr, tv[i].wd, tv[i].rb, tv[i].re, tv[i].fl, tv[i].dt);
            step();
            chk($sformatf("v%0d cnt", i), a_cnt, cyc);
            chk($sformatf("v%0d beg", i), a_beg, tv[i].e_beg);
            chk($sformatf("v%0d thr", i), a_thr, tv[i].e_thr);
            chk($sformatf("v%0d open", i), {31'd0, a_open}, {31'd0, tv[i].e_open});
            chk($sformatf("v%0d exp", i), {31'd0, a_exp}, {31'd0, tv[i].e_exp});
            rd_a(tv[i].raddr, tv[i].e_rd, $sformatf("v%0d rd", i));
        end

        // Region at cycle 100 with THRESHOLD=5; a write of 9 mid-window must not affect it.
        drv(1, 2'd1, 32'd5, 0, 0, 0, 0);
        step();
        idle();
        while (cyc < 100) step();
        drv(0, 2'd0, 0, 1, 0, 0, 0);
        step();
        chk("w100 beg", a_beg, 100);
        chk("w100 thr", a_thr, 5);
        chk("w100 open", {31'd0, a_open}, 1);
        for (int j = 0; j < 9; j++) begin
            if (j == 2) drv(1, 2'd1, 32'd9, 0, 0, 0, 1);
            else        drv(0, 2'd0, 0, 0, 0, 0, 1);
            step();
            chk($sformatf("w100 exp@%0d", cyc), {31'd0, a_exp}, {31'd0, (cyc >= 107)});
            chk($sformatf("w100 thr@%0d", cyc), a_thr, 5);
        end
        rd_a(2'd3, 3, "w100 stats");
        rd_a(2'd1, 9, "w100 shadow");
        drv(0, 2'd0, 0, 0, 1, 0, 0);
        step();
        chk("w100 end open", {31'd0, a_open}, 0);
        c0 = cyc;
        drv(0, 2'd0, 0, 1, 0, 0, 0);
        step();
        chk("next region beg", a_beg, c0);
        chk("next region thr", a_thr, 9);
        drv(0, 2'd0, 0, 0, 1, 0, 0);
        step();

        // Largest threshold that still fits: no rebase.
        c0 = cyc;
        wd = 32'hFFFF_FFFE - c0;
        drv(1, 2'd1, wd, 1, 0, 0, 0);
        step();
        chk("norebase cnt", a_cnt, c0 + 1);
        chk("norebase beg", a_beg, c0);
        chk("norebase thr", a_thr, wd);
        drv(0, 2'd0, 0, 0, 0, 1, 0);
        step();

        // One more and the window end overflows: counter and begin both rebase to 0.
        c0 = cyc;
        wd = 32'hFFFF_FFFF - c0;
        drv(1, 2'd1, wd, 1, 0, 0, 0);
        step();
        cyc = 0;
        chk("rebase cnt", a_cnt, 0);
        chk("rebase beg", a_beg, 0);
        chk("rebase thr", a_thr, wd);
        idle();
        step();
        chk("rebase cnt+1", a_cnt, 1);
        chk("rebase open", {31'd0, a_open}, 1);
        chk("rebase exp", {31'd0, a_exp}, 0);

        // Asynchronous reset between edges while counting.
        #2;
        rst_a = 1'b0;
        #1;
        chk("areset cnt", a_cnt, 0);
        chk("areset beg", a_beg, 0);
        chk("areset thr", a_thr, 0);
        chk("areset open", {31'd0, a_open}, 0);
        chk("areset exp", {31'd0, a_exp}, 0);
        chk("areset state", {30'd0, a_state}, 0);
        rd_a(2'd1, 0, "areset shadow");
        @(negedge clk);

        // 8-bit instance: wrap-forced rebase at 0xF0 with THRESHOLD=0x20.
        rst_b = 1'b1;
        cyc = 0;
        drv(1, 2'd0, 32'h1, 0, 0, 0, 0);
        step();
        drv(1, 2'd1, 32'h20, 0, 0, 0, 0);
        step();
        idle();
        while (cyc < 8'hF0) step();
        chk("b pre cnt", {24'd0, b_cnt}, 32'hF0);
        drv(0, 2'd0, 0, 1, 0, 0, 0);
        step();
        cyc = 0;
        chk("b rebase cnt", {24'd0, b_cnt}, 0);
        chk("b rebase beg", {24'd0, b_beg}, 0);
        chk("b rebase thr", {24'd0, b_thr}, 32'h20);
        while (cyc < 8'h38) begin
            drv(0, 2'd0, 0, 0, 0, 0, 1);
            step();
            if (cyc >= 8'h1F && cyc <= 8'h24)
                chk($sformatf("b exp@%0h", cyc), {31'd0, b_exp}, {31'd0, (cyc >= 8'h22)});
        end
        rd_b(2'd3, 32'hF, "b stats sat");

        // Clear beats a same-cycle increment; enable bit kept at 1 so the window stays.
        drv(1, 2'd0, 32'h3, 0, 0, 0, 1);
        step();
        chk("b clear exp", {31'd0, b_exp}, 1);
        rd_b(2'd3, 0, "b stats clear");
        drv(0, 2'd0, 0, 0, 0, 1, 1);
        step();
        chk("b flush open", {31'd0, b_open}, 0);
        chk("b flush exp", {31'd0, b_exp}, 0);
        rd_b(2'd3, 1, "b stats post");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
